// File: rtl/slc3_control.sv
// slc3_control: Moore FSM that sequences the SLC-3 datapath through fetch, decode and execute.
// Latency: S18 to decode takes 3+MEM_WAIT cycles; outputs decode from the state register only.
// Backpressure: memory is a fixed MEM_WAIT-cycle access; PAUSE holds until one Continue press and release.
module slc3_control #(
    parameter int MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DR,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       MIO_EN,
    output logic       Mem_RD,
    output logic       Mem_WR
);

    typedef enum logic [4:0] {
        HALTED, S18, S33, S35, S32,
        S1, S5, S9, S0, S22, S12,
        S4, S21, S6, S7, S25, S27,
        S23, S16, P1, P2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] cnt;
    logic [2:0] cnt_nxt;
    logic       cnt_last;

    // Only JSR with offset11 exists, so the JSR/JSRR select bit is not decoded.
    logic unused_ir11;
    assign unused_ir11 = IR_11;

    assign cnt_last = (cnt == 3'(MEM_WAIT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= HALTED;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = '0;
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = 2'b00;
        DR         = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = 2'b00;
        ALUK       = 2'b00;
        MIO_EN     = 1'b0;
        Mem_RD     = 1'b0;
        Mem_WR     = 1'b0;

        case (state)
            HALTED: begin
                if (Run) state_nxt = S18;
            end
            S18: begin
                GatePC    = 1'b1;
                LD_MAR    = 1'b1;
                PCMUX     = 2'b00;
                LD_PC     = 1'b1;
                state_nxt = S33;
            end
            // Read waits hold the counter until the last cycle, when MDR captures memory data.
            S33, S25: begin
                Mem_RD = 1'b1;
                MIO_EN = 1'b1;
                if (cnt_last) begin
                    LD_MDR    = 1'b1;
                    state_nxt = (state == S33) ? S35 : S27;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            S35: begin
                GateMDR   = 1'b1;
                LD_IR     = 1'b1;
                state_nxt = S32;
            end
            S32: begin
                LD_BEN = 1'b1;
                case (Opcode)
                    4'b0001: state_nxt = S1;
                    4'b0101: state_nxt = S5;
                    4'b1001: state_nxt = S9;
                    4'b0000: state_nxt = S0;
                    4'b1100: state_nxt = S12;
                    4'b0100: state_nxt = S4;
                    4'b0110: state_nxt = S6;
                    4'b0111: state_nxt = S7;
                    4'b1101: state_nxt = P1;
                    default: state_nxt = S18;
                endcase
            end
            S1, S5, S9: begin
                SR1MUX    = 1'b1;
                SR2MUX    = (state == S9) ? 1'b0 : ~IR_5;
                ALUK      = (state == S1) ? 2'b00 : (state == S5) ? 2'b01 : 2'b10;
                GateALU   = 1'b1;
                DR        = 1'b1;
                LD_REG    = 1'b1;
                LD_CC     = 1'b1;
                state_nxt = S18;
            end
            S0: begin
                state_nxt = BEN ? S22 : S18;
            end
            S22: begin
                ADDR1MUX  = 1'b1;
                ADDR2MUX  = 2'b01;
                PCMUX     = 2'b01;
                LD_PC     = 1'b1;
                state_nxt = S18;
            end
            S12: begin
                SR1MUX    = 1'b1;
                ADDR1MUX  = 1'b0;
                ADDR2MUX  = 2'b11;
                PCMUX     = 2'b01;
                LD_PC     = 1'b1;
                state_nxt = S18;
            end
            S4: begin
                GatePC    = 1'b1;
                DR        = 1'b0;
                LD_REG    = 1'b1;
                state_nxt = S21;
            end
            S21: begin
                ADDR1MUX  = 1'b1;
                ADDR2MUX  = 2'b00;
                PCMUX     = 2'b01;
                LD_PC     = 1'b1;
                state_nxt = S18;
            end
            S6, S7: begin
                SR1MUX     = 1'b1;
                ADDR1MUX   = 1'b0;
                ADDR2MUX   = 2'b10;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                state_nxt  = (state == S6) ? S25 : S23;
            end
            S27: begin
                GateMDR   = 1'b1;
                DR        = 1'b1;
                LD_REG    = 1'b1;
                LD_CC     = 1'b1;
                state_nxt = S18;
            end
            S23: begin
                SR1MUX    = 1'b0;
                ALUK      = 2'b11;
                GateALU   = 1'b1;
                MIO_EN    = 1'b0;
                LD_MDR    = 1'b1;
                state_nxt = S16;
            end
            S16: begin
                Mem_WR = 1'b1;
                if (cnt_last) begin
                    state_nxt = S18;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            // Two-phase handshake: a held Continue releases exactly one PAUSE.
            P1: begin
                LD_LED = 1'b1;
                if (Continue) state_nxt = P2;
            end
            P2: begin
                if (!Continue) state_nxt = S18;
            end
            default: begin
                state_nxt = HALTED;
            end
        endcase
    end

endmodule

// File: tb/tb_slc3_control.sv
// Bench for slc3_control: per-instruction expected control traces built from the state-sequence rules.
module tb_slc3_control;
    localparam int MW = 2;
    localparam int F  = 3 + MW;

    logic clk = 1'b0;
    logic reset, Run, Continue, IR_5, IR_11, BEN;
    logic [3:0] Opcode;
    logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic DR, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, Mem_RD, Mem_WR;

    slc3_control #(.MEM_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
        .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
        .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
        .PCMUX(PCMUX), .DR(DR), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
        .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .MIO_EN(MIO_EN), .Mem_RD(Mem_RD), .Mem_WR(Mem_WR)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux;
        logic dr, sr1mux, sr2mux, addr1mux;
        logic [1:0] addr2mux, aluk;
        logic mio_en, mem_rd, mem_wr;
    } ctl_t;

    typedef struct {
        logic [3:0] op;
        logic       ir5;
        logic       ben;
        int         len;
        int         ldpc;
        int         ldreg;
        int         wr;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    ctl_t exp_q[$];
    bit   cin_q[$];
    bit   pause_pat[$];

    function automatic ctl_t observe();
        ctl_t o;
        o = '{ld_mar: LD_MAR, ld_mdr: LD_MDR, ld_ir: LD_IR, ld_ben: LD_BEN, ld_cc: LD_CC,
              ld_reg: LD_REG, ld_pc: LD_PC, ld_led: LD_LED, gate_pc: GatePC, gate_mdr: GateMDR,
              gate_alu: GateALU, gate_marmux: GateMARMUX, pcmux: PCMUX, dr: DR, sr1mux: SR1MUX,
              sr2mux: SR2MUX, addr1mux: ADDR1MUX, addr2mux: ADDR2MUX, aluk: ALUK,
              mio_en: MIO_EN, mem_rd: Mem_RD, mem_wr: Mem_WR};
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctl(string name, int idx, ctl_t exp);
        ctl_t act;
        act = observe();
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Reference: the control vector of every cycle of one instruction, S18 through its last state.
    function automatic void push(ctl_t c);
        exp_q.push_back(c);
        cin_q.push_back(1'($urandom_range(0, 1)));
    endfunction

    function automatic void push_mem(bit wr);
        ctl_t c;
        for (int i = 0; i < MW; i++) begin
            c = '0;
            if (wr) c.mem_wr = 1'b1;
            else begin
                c.mem_rd = 1'b1;
                c.mio_en = 1'b1;
                c.ld_mdr = (i == MW - 1);
            end
            push(c);
        end
    endfunction

    function automatic void build(logic [3:0] op, logic ir5, logic ben);
        ctl_t c;
        int   i;
        exp_q.delete();
        cin_q.delete();
        c = '0; c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; push(c);
        push_mem(1'b0);
        c = '0; c.gate_mdr = 1; c.ld_ir = 1; push(c);
        c = '0; c.ld_ben = 1; push(c);
        c = '0;
        case (op)
            4'b0001, 4'b0101, 4'b1001: begin
                c.sr1mux = 1; c.gate_alu = 1; c.dr = 1; c.ld_reg = 1; c.ld_cc = 1;
                c.sr2mux = (op == 4'b1001) ? 1'b0 : ~ir5;
                c.aluk   = (op == 4'b0001) ? 2'd0 : (op == 4'b0101) ? 2'd1 : 2'd2;
                push(c);
            end
            4'b0000: begin
                push(c);
                if (ben) begin
                    c.addr1mux = 1; c.addr2mux = 2'b01; c.pcmux = 2'b01; c.ld_pc = 1;
                    push(c);
                end
            end
            4'b1100: begin
                c.sr1mux = 1; c.addr2mux = 2'b11; c.pcmux = 2'b01; c.ld_pc = 1; push(c);
            end
            4'b0100: begin
                c.gate_pc = 1; c.ld_reg = 1; push(c);
                c = '0; c.addr1mux = 1; c.pcmux = 2'b01; c.ld_pc = 1; push(c);
            end
            4'b0110, 4'b0111: begin
                c.sr1mux = 1; c.addr2mux = 2'b10; c.gate_marmux = 1; c.ld_mar = 1; push(c);
                c = '0;
                if (op == 4'b0110) begin
                    push_mem(1'b0);
                    c.gate_mdr = 1; c.dr = 1; c.ld_reg = 1; c.ld_cc = 1; push(c);
                end else begin
                    c.aluk = 2'b11; c.gate_alu = 1; c.ld_mdr = 1; push(c);
                    push_mem(1'b1);
                end
            end
            4'b1101: begin
                // LED phase lasts through the first pressed cycle, wait phase through the first released one.
                i = 0;
                c.ld_led = 1;
                while (1) begin
                    exp_q.push_back(c); cin_q.push_back(pause_pat[i]);
                    if (pause_pat[i]) break;
                    i++;
                end
                c = '0;
                while (1) begin
                    i++;
                    exp_q.push_back(c); cin_q.push_back(pause_pat[i]);
                    if (!pause_pat[i]) break;
                end
            end
            default: ;
        endcase
    endfunction

    // Entered one cycle after the S18 edge; returns once the next fetch (S18) is seen.
    task automatic run_instr(string name, logic [3:0] op, logic ir5, logic ben,
                             output int len, output int ldpc, output int ldreg,
                             output int wr, output int led);
        ctl_t o;
        int   k;
        build(op, ir5, ben);
        Opcode = op; IR_5 = ir5; BEN = ben; IR_11 = 1'($urandom_range(0, 1));
        ldpc = 0; ldreg = 0; wr = 0; led = 0;
        k = 0;
        while (k < 100) begin
            o = observe();
            if (k > 0 && o.ld_mar && o.gate_pc && o.ld_pc) break;
            if (k < exp_q.size()) check_ctl(name, k, exp_q[k]);
            ldpc  += int'(o.ld_pc);
            ldreg += int'(o.ld_reg);
            wr    += int'(o.mem_wr);
            led   += int'(o.ld_led);
            Continue = (k < cin_q.size()) ? cin_q[k] : 1'b0;
            Run = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        if (k >= 100) begin
            n_cmp++; n_bad++;
            $display("FAIL %s timeout: no return to fetch within 100 cycles", name);
        end
        len = k;
        check_int({name, " len"}, len, exp_q.size());
    endtask

    vec_t tbl[12];
    ctl_t s18_v;
    int   len, ldpc, ldreg, wr, led;

    initial begin
        tbl[0]  = '{4'b0001, 1'b1, 1'b0, F + 1, 1, 1, 0};
        tbl[1]  = '{4'b0001, 1'b0, 1'b1, F + 1, 1, 1, 0};
        tbl[2]  = '{4'b0101, 1'b1, 1'b0, F + 1, 1, 1, 0};
        tbl[3]  = '{4'b1001, 1'b0, 1'b0, F + 1, 1, 1, 0};
        tbl[4]  = '{4'b0000, 1'b0, 1'b0, F + 1, 1, 0, 0};
        tbl[5]  = '{4'b0000, 1'b0, 1'b1, F + 2, 2, 0, 0};
        tbl[6]  = '{4'b1100, 1'b0, 1'b0, F + 1, 2, 0, 0};
        tbl[7]  = '{4'b0100, 1'b1, 1'b0, F + 2, 2, 1, 0};
        tbl[8]  = '{4'b0110, 1'b0, 1'b0, F + 2 + MW, 1, 1, 0};
        tbl[9]  = '{4'b0111, 1'b0, 1'b0, F + 2 + MW, 1, 0, MW};
        tbl[10] = '{4'b1111, 1'b0, 1'b0, F, 1, 0, 0};
        tbl[11] = '{4'b0010, 1'b1, 1'b1, F, 1, 0, 0};
        s18_v = '0; s18_v.gate_pc = 1; s18_v.ld_mar = 1; s18_v.ld_pc = 1;

        reset = 1'b0; Run = 1'b1; Continue = 1'b0; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;
        Opcode = 4'b0000;
        tick(); check_ctl("reset_c1", 0, '0);
        tick(); check_ctl("reset_c2", 1, '0);
        reset = 1'b1; Run = 1'b0;
        tick(); check_ctl("halt_idle", 0, '0);
        Run = 1'b1;
        tick(); check_ctl("run_s18", 0, s18_v);

        for (int v = 0; v < 12; v++) begin
            run_instr($sformatf("tbl%0d", v), tbl[v].op, tbl[v].ir5, tbl[v].ben,
                      len, ldpc, ldreg, wr, led);
            check_int($sformatf("tbl%0d cycles", v), len, tbl[v].len);
            check_int($sformatf("tbl%0d ld_pc", v), ldpc, tbl[v].ldpc);
            check_int($sformatf("tbl%0d ld_reg", v), ldreg, tbl[v].ldreg);
            check_int($sformatf("tbl%0d mem_wr", v), wr, tbl[v].wr);
        end

        // Continue held for ten cycles releases exactly one PAUSE.
        pause_pat.delete();
        pause_pat.push_back(1'b0); pause_pat.push_back(1'b0);
        for (int i = 0; i < 10; i++) pause_pat.push_back(1'b1);
        pause_pat.push_back(1'b0);
        run_instr("pause", 4'b1101, 1'b0, 1'b0, len, ldpc, ldreg, wr, led);
        check_int("pause led", led, 3);
        check_int("pause cycles", len, F + 13);

        // Reset in the first write-wait cycle of a store.
        build(4'b0111, 1'b0, 1'b0);
        Opcode = 4'b0111;
        for (int k = 0; k < MW + 5; k++) begin
            check_ctl("st_pre", k, exp_q[k]);
            Continue = 1'b0; Run = 1'b0;
            tick();
        end
        check_ctl("st_s16", MW + 5, exp_q[MW + 5]);
        reset = 1'b0; Run = 1'b1;
        tick(); check_ctl("st_reset", 0, '0);
        tick(); check_ctl("st_reset_hold", 1, '0);
        reset = 1'b1; Run = 1'b0;
        tick(); check_ctl("st_halt", 0, '0);
        Run = 1'b1;
        tick(); check_ctl("st_rerun", 0, s18_v);

        for (int r = 0; r < 40; r++) begin
            pause_pat.delete();
            for (int i = 0; i < $urandom_range(0, 3); i++) pause_pat.push_back(1'b0);
            for (int i = 0; i < $urandom_range(1, 4); i++) pause_pat.push_back(1'b1);
            pause_pat.push_back(1'b0);
            run_instr($sformatf("rnd%0d", r), 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      len, ldpc, ldreg, wr, led);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/slc3_control.md
Name: slc3_control

Overview:
- Moore finite-state control unit that sequences the SLC-3 datapath through fetch, decode and execute.
- Drives every load, gate and mux-select input of the datapath, plus memory read/write strobes.
- Consumes the opcode and mode bits of IR and the BEN flag from the datapath, and Run/Continue from the top level.
- Memory latency is covered by a programmable wait counter.

Parameters:
- MEM_WAIT, 2, number of wait cycles (1..7) spent in each memory-access state before data is valid or a write is committed.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- Run  input  1  start execution from Halted
- Continue  input  1  release from a PAUSE instruction
- Opcode  input  4  IR[15:12]
- IR_5  input  1  immediate-mode bit
- IR_11  input  1  JSR/JSRR select (only JSR with offset11 is implemented)
- BEN  input  1  branch-enable from datapath
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  output  1 each  register loads
- GatePC, GateMDR, GateALU, GateMARMUX  output  1 each  bus drivers; at most one high per cycle
- PCMUX  output  2  00 PC+1, 01 adder, 10 bus
- DR  output  1  0 selects R7, 1 selects IR[11:9]
- SR1MUX  output  1  0 IR[11:9], 1 IR[8:6]
- SR2MUX  output  1  0 SEXT5, 1 register SR2
- ADDR1MUX  output  1  0 SR1, 1 PC
- ADDR2MUX  output  2  00 SEXT11, 01 SEXT9, 10 SEXT6, 11 zero
- ALUK  output  2  00 ADD, 01 AND, 10 NOT, 11 PASS A
- MIO_EN  output  1  1 = MDR loads from memory, 0 = MDR loads from bus
- Mem_RD, Mem_WR  output  1 each  memory strobes, active high

Behaviour:
- State register and the 3-bit wait counter update only on the rising clk edge.
- All outputs decode combinationally from state only (Moore); outputs not listed for a state are 0.
- reset=0 at any edge, including mid-instruction or mid-wait, forces Halted and clears the counter. No memory strobe is asserted in Halted.
- Halted: stay while Run=0; on Run=1 go to S18.
- S18: GatePC, LD_MAR, PCMUX=00, LD_PC. Go to S33.
- S33 (memory read wait): Mem_RD=1, MIO_EN=1. The counter counts 0..MEM_WAIT-1. LD_MDR asserts only on the final count; the counter then clears and the FSM goes to S35.
- S35: GateMDR, LD_IR. Go to S32.
- S32: LD_BEN. Decode Opcode:
  - 0001 → S1; 0101 → S5; 1001 → S9; 0000 → S0; 1100 → S12
  - 0100 → S4; 0110 → S6; 0111 → S7; 1101 → P1
  - any other opcode → S18 (no-op)
- S1/S5: SR1MUX=1, SR2MUX=~IR_5, ALUK=00 (S1) or 01 (S5), GateALU, DR=1, LD_REG, LD_CC. Go to S18.
- S9: same as S1/S5 except ALUK=10, SR2MUX=0. Go to S18.
- S0: if BEN go to S22, else go to S18.
- S22: ADDR1MUX=1, ADDR2MUX=01, PCMUX=01, LD_PC. Go to S18.
- S12: SR1MUX=1, ADDR1MUX=0, ADDR2MUX=11, PCMUX=01, LD_PC. Go to S18.
- S4: GatePC, DR=0, LD_REG (R7←PC). Go to S21.
- S21: ADDR1MUX=1, ADDR2MUX=00, PCMUX=01, LD_PC. Go to S18.
- S6/S7: SR1MUX=1, ADDR1MUX=0, ADDR2MUX=10, GateMARMUX, LD_MAR. S6 goes to S25; S7 goes to S23.
- S25: identical to S33, then go to S27.
- S27: GateMDR, DR=1, LD_REG, LD_CC. Go to S18.
- S23: SR1MUX=0, ALUK=11, GateALU, MIO_EN=0, LD_MDR. Go to S16.
- S16: Mem_WR=1 for MEM_WAIT cycles (counter as in S33). Go to S18.
- P1: LD_LED; wait for Continue=1, then go to P2.
- P2: wait for Continue=0, then go to S18. This two-phase handshake makes one held Continue press release exactly one PAUSE.
- Run is ignored outside Halted. Continue is ignored outside P1/P2.

Test Plan:
- reset=0 for 2 cycles with Run=1 → state Halted, all outputs 0. Release reset, Run=1 → S18 next cycle with GatePC=LD_MAR=LD_PC=1.
- Fetch with MEM_WAIT=2 → Mem_RD high exactly 2 cycles, LD_MDR high only on the 2nd, LD_IR one cycle later; S18→S32 takes 5 cycles.
- Opcode=0001, IR_5=1 → S1 with SR2MUX=0, ALUK=00, GateALU=LD_REG=LD_CC=1, then back to S18. Repeat with IR_5=0 → SR2MUX=1.
- Opcode=0000: with BEN=0 → S0→S18, LD_PC never high. With BEN=1 → S22 with PCMUX=01, ADDR2MUX=01, ADDR1MUX=1.
- Opcode=0111 → S7, S23, S16 with Mem_WR high MEM_WAIT cycles and never overlapping Mem_RD. Assert reset=0 during S16 → Halted next edge, Mem_WR=0.
- Opcode=1101, Continue held high 10 cycles → exactly one exit from P1, FSM stays in P2 until Continue=0, then S18; LD_LED high only in P1.
